cache_mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction cache and the data cache.
- Sits between both cache controllers and data memory.
- The data side is driven from the decoder's d_mem_r/d_mem_w path after a D-cache miss; the instruction side is driven by I-cache line fills.
- Grants one requester at a time, holds the memory strobes stable for the whole transaction, and returns the line with a one-cycle response.

---
 rtl/cache_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache line traffic.
// One requester owns memory at a time; the strobes, address and write line
// are registered and held for the whole transaction. The owner gets its line
// back with a single-cycle response state before the port is re-arbitrated.
module cache_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D} state_e;
  typedef enum logic {SIDE_I, SIDE_D} side_e;

  state_e              state_q, state_d;
  side_e               last_grant_q, last_grant_d;
  logic                seen_busy_q, seen_busy_d;
  logic [DATA_W-1:0]   i_readdata_q, i_readdata_d;
  logic [DATA_W-1:0]   d_readdata_q, d_readdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;

  logic i_req, d_req, grant_i, grant_d;

  // Request decode and arbitration: on a conflict round-robin picks the side
  // that did not win last time, fixed priority always picks the D-cache.
  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign grant_i = i_req & (~d_req | (RR_EN && (last_grant_q == SIDE_D)));
  assign grant_d = d_req & ~grant_i;

  // Stalls are combinational so a requester stalls in the cycle it asks,
  // and only its own response cycle releases it.
  assign i_busywait = i_req & (state_q != RESP_I);
  assign d_busywait = d_req & (state_q != RESP_D);

  assign i_readdata    = i_readdata_q;
  assign d_readdata    = d_readdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

  // Next-state and next-register computation for the arbiter FSM.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    seen_busy_d     = seen_busy_q;
    i_readdata_d    = i_readdata_q;
    d_readdata_d    = d_readdata_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d       = GRANT_I;
          last_grant_d  = SIDE_I;
          seen_busy_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = i_address;
        end else if (grant_d) begin
          // A simultaneous read and write is served as the write-back.
          state_d         = GRANT_D;
          last_grant_d    = SIDE_D;
          seen_busy_d     = 1'b0;
          mem_read_d      = d_read & ~d_write;
          mem_write_d     = d_write;
          mem_address_d   = d_address;
          mem_writedata_d = d_writedata;
        end
      end
      GRANT_I, GRANT_D: begin
        // Memory must show busy at least once before its idle level means done.
        if (mem_busywait) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          if (mem_read_q) begin
            if (state_q == GRANT_I) i_readdata_d = mem_readdata;
            else                    d_readdata_d = mem_readdata;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = (state_q == GRANT_I) ? RESP_I : RESP_D;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that overrides everything.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RESET) begin
      state_q         <= IDLE;
      last_grant_q    <= SIDE_I;
      seen_busy_q     <= 1'b0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      seen_busy_q     <= seen_busy_d;
      i_readdata_q    <= i_readdata_d;
      d_readdata_q    <= d_readdata_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter. Two instances run side by side
// on the same cache stimulus: index 0 is round-robin, index 1 is fixed
// priority. Each has its own memory responder and transaction-level model;
// a compare process checks every output on every falling edge.
module tb_cache_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int SI = 1;  // model side codes: 0 none, 1 I-cache, 2 D-cache
  localparam int SD = 2;

  logic CLK = 1'b0;
  logic RESET;
  logic i_read, d_read, d_write;
  logic [AW-1:0] i_address, d_address;
  logic [DW-1:0] d_writedata;

  logic [1:0][DW-1:0] i_rd, d_rd, m_wd, m_rdata;
  logic [1:0][AW-1:0] m_ad;
  logic [1:0]         i_bw, d_bw, m_r, m_w, m_bw;

  int total = 0;
  int bad   = 0;
  int lat   = 4;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) u_rr (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_rd[0]), .i_busywait(i_bw[0]),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_rd[0]), .d_busywait(d_bw[0]),
    .mem_read(m_r[0]), .mem_write(m_w[0]), .mem_address(m_ad[0]), .mem_writedata(m_wd[0]),
    .mem_readdata(m_rdata[0]), .mem_busywait(m_bw[0])
  );

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) u_fp (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_rd[1]), .i_busywait(i_bw[1]),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_rd[1]), .d_busywait(d_bw[1]),
    .mem_read(m_r[1]), .mem_write(m_w[1]), .mem_address(m_ad[1]), .mem_writedata(m_wd[1]),
    .mem_readdata(m_rdata[1]), .mem_busywait(m_bw[1])
  );

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    return {32'hDEADBEEF, 68'd0, a};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory responder: raises busy in the first strobe cycle, holds it for
  // 'lat' rising edges, then drops it with the line for reads.
  int cnt [2];
  bit act [2];
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (RESET === 1'b1 || !(m_r[k] | m_w[k])) begin
        act[k] = 1'b0; m_bw[k] = 1'b0;
      end else if (!act[k]) begin
        act[k] = 1'b1; cnt[k] = lat - 1; m_bw[k] = 1'b1;
      end else if (cnt[k] > 0) begin
        cnt[k]--;
      end else if (m_bw[k]) begin
        m_bw[k] = 1'b0;
        m_rdata[k] = m_r[k] ? line_of(m_ad[k]) : ~line_of(m_ad[k]);
      end
    end
  end

  // Transaction-level model: who owns memory, who is in its response cycle,
  // what the registered outputs must hold.
  int owner [2], resp [2], last [2];
  bit seen [2], e_rd [2], e_wr [2];
  logic [AW-1:0] e_ad [2];
  logic [DW-1:0] e_wd [2], e_ird [2], e_drd [2];
  bit chk_en = 1'b0;

  function automatic int pick(input int k, input bit ir, input bit dr, input int lst);
    if (ir && !dr) return SI;
    if (dr && !ir) return SD;
    if (ir && dr)  return (k == 0) ? ((lst == SI) ? SD : SI) : SD;
    return 0;
  endfunction

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (RESET) begin
        owner[k] = 0; resp[k] = 0; last[k] = SI; seen[k] = 1'b0;
        e_rd[k] = 1'b0; e_wr[k] = 1'b0; e_ad[k] = '0; e_wd[k] = '0;
        e_ird[k] = '0; e_drd[k] = '0; chk_en = 1'b1;
      end else if (resp[k] != 0) begin
        resp[k] = 0;
      end else if (owner[k] != 0) begin
        if (m_bw[k]) seen[k] = 1'b1;
        else if (seen[k]) begin
          if (e_rd[k] && owner[k] == SI) e_ird[k] = m_rdata[k];
          if (e_rd[k] && owner[k] == SD) e_drd[k] = m_rdata[k];
          e_rd[k] = 1'b0; e_wr[k] = 1'b0;
          resp[k] = owner[k]; owner[k] = 0;
        end
      end else begin
        owner[k] = pick(k, i_read, d_read | d_write, last[k]);
        if (owner[k] != 0) begin
          last[k] = owner[k]; seen[k] = 1'b0;
          if (owner[k] == SI) begin
            e_rd[k] = 1'b1; e_wr[k] = 1'b0; e_ad[k] = i_address;
          end else begin
            e_rd[k] = d_read & ~d_write; e_wr[k] = d_write;
            e_ad[k] = d_address; e_wd[k] = d_writedata;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, plus a log of
  // the address of each new memory transaction as seen on the DUT pins.
  logic [AW-1:0] glog_rr [$];
  logic [AW-1:0] glog_fp [$];
  bit prev_s [2] = '{1'b0, 1'b0};
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (chk_en) begin
        string p;
        p = (k == 0) ? "rr" : "fp";
        check({p, ".mem_read"},    m_r[k],  e_rd[k]);
        check({p, ".mem_write"},   m_w[k],  e_wr[k]);
        check({p, ".mem_address"}, m_ad[k], e_ad[k]);
        if (e_wr[k]) check({p, ".mem_writedata"}, m_wd[k], e_wd[k]);
        check({p, ".i_readdata"},  i_rd[k], e_ird[k]);
        check({p, ".d_readdata"},  d_rd[k], e_drd[k]);
        check({p, ".i_busywait"},  i_bw[k], i_read & (resp[k] != SI));
        check({p, ".d_busywait"},  d_bw[k], (d_read | d_write) & (resp[k] != SD));
        if ((m_r[k] | m_w[k]) && !prev_s[k]) begin
          if (k == 0) glog_rr.push_back(m_ad[k]);
          else        glog_fp.push_back(m_ad[k]);
        end
        prev_s[k] = m_r[k] | m_w[k];
      end
    end
  end

  // Bounded wait on the round-robin instance (or on both going quiet).
  task automatic wait_cond(input int which, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      @(negedge CLK);
      case (which)
        0: hit = m_r[0];
        1: hit = !i_bw[0];
        2: hit = !d_bw[0];
        3: hit = m_w[0];
        default: hit = !i_read && !d_read && !d_write &&
                       owner[0] == 0 && resp[0] == 0 && owner[1] == 0 && resp[1] == 0;
      endcase
    end
    check({"wait.", name}, hit, 1'b1);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  int s_rr, s_fp, nd, nrr, nfp;

  initial begin
    RESET = 1'b1; i_read = 1'b1; i_address = 28'h10;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
    m_bw = '0; m_rdata = '0;

    // Reset held two edges with an I request pending.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst.mem_read", m_r[0], 1'b0);
    check("rst.i_busywait", i_bw[0], 1'b1);
    check("rst.i_readdata", i_rd[0], 128'h0);
    @(posedge CLK); #1 RESET = 1'b0;

    // Single I-fill, memory busy 4 cycles.
    wait_cond(0, "t2.rd");
    check("t2.addr", m_ad[0], 28'h0000010);
    check("t2.d_bw", d_bw[0], 1'b0);
    wait_cond(1, "t2.resp");
    check("t2.line", i_rd[0], 128'hDEADBEEF_00000000_00000000_00000010);
    @(negedge CLK);
    check("t2.bw_one_cycle", i_bw[0], 1'b1);
    tick(); i_read = 1'b0;  // request dropped inside a new grant
    wait_cond(4, "t2.idle");

    // Conflict: last grant was I, so D goes first under both policies.
    tick(); lat = 3;
    i_read = 1'b1; d_read = 1'b1; i_address = 28'h30; d_address = 28'h50;
    wait_cond(0, "t3.rd1");
    check("t3.d_first", m_ad[0], 28'h50);
    wait_cond(2, "t3.resp_d");
    check("t3.d_line", d_rd[0], 128'hDEADBEEF_00000000_00000000_00000050);
    check("t3.i_stalled", i_bw[0], 1'b1);
    tick(); d_read = 1'b0;
    wait_cond(0, "t3.rd2");
    check("t3.i_second", m_ad[0], 28'h30);
    wait_cond(1, "t3.resp_i");
    check("t3.i_line", i_rd[0], 128'hDEADBEEF_00000000_00000000_00000030);
    tick(); i_read = 1'b0;
    wait_cond(4, "t3.idle");

    // Write-back then fill.
    tick(); lat = 2;
    d_write = 1'b1; d_address = 28'h20; d_writedata = {16{8'hA5}};
    wait_cond(3, "t4.wr");
    check("t4.wdata", m_wd[0], 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5);
    check("t4.waddr", m_ad[0], 28'h20);
    check("t4.no_rd", m_r[0], 1'b0);
    wait_cond(2, "t4.resp_w");
    check("t4.rdata_kept", d_rd[0], 128'hDEADBEEF_00000000_00000000_00000050);
    tick(); d_write = 1'b0; d_read = 1'b1; d_address = 28'h40;
    wait_cond(0, "t4.rd");
    check("t4.raddr", m_ad[0], 28'h40);
    wait_cond(2, "t4.resp_r");
    check("t4.rline", d_rd[0], 128'hDEADBEEF_00000000_00000000_00000040);
    tick(); d_read = 1'b0;
    wait_cond(4, "t4.idle");

    // Continuous contention; last grant was D on both instances.
    tick(); lat = 1;
    s_rr = glog_rr.size(); s_fp = glog_fp.size();
    i_read = 1'b1; d_read = 1'b1; i_address = 28'h70; d_address = 28'h80;
    repeat (40) @(posedge CLK);
    #1 d_read = 1'b0;
    repeat (16) @(posedge CLK);
    #1 i_read = 1'b0;
    wait_cond(4, "t5.idle");
    nrr = glog_rr.size() - s_rr;
    nfp = glog_fp.size() - s_fp;
    check("t5.rr_count", nrr >= 6, 1'b1);
    if (nrr >= 6)
      for (int j = 0; j < 6; j++)
        check("t5.rr_alternate", glog_rr[s_rr + j], (j % 2 == 0) ? 28'h70 : 28'h80);
    nd = 0;
    while (nd < nfp && glog_fp[s_fp + nd] == 28'h80) nd++;
    check("t5.fp_d_run", nd >= 3, 1'b1);
    check("t5.fp_i_after", nfp > nd, 1'b1);
    for (int j = nd; j < nfp; j++)
      check("t5.fp_only_i", glog_fp[s_fp + j], 28'h70);

    // Reset in the middle of an I grant while memory is busy.
    tick(); lat = 6;
    i_read = 1'b1; i_address = 28'h60;
    wait_cond(0, "t6.rd");
    @(negedge CLK);
    check("t6.busy_before", m_r[0], 1'b1);
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("t6.rd_low", m_r[0], 1'b0);
    check("t6.wr_low", m_w[0], 1'b0);
    check("t6.i_bw", i_bw[0], 1'b1);
    check("t6.i_rdata", i_rd[0], 128'h0);
    @(posedge CLK); #1 RESET = 1'b0; i_read = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("t6.no_grant", m_r[0], 1'b0);
    end
    wait_cond(4, "t6.idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
